// File: rtl/ddi_phase_scheduler_if.sv
// Handshake bundle between the DDI phase scheduler (master) and the light
// controller (slave).
interface ddi_phase_scheduler_if;
  logic       maintenance;
  logic       east_req;
  logic       west_req;
  logic [3:0] current_state;
  logic [1:0] phase;
  logic       timing_done;
  logic       east_pending;
  logic       west_pending;

  modport master (
    input  maintenance, east_req, west_req, current_state,
    output phase, timing_done, east_pending, west_pending
  );

  modport slave (
    output maintenance, east_req, west_req, current_state,
    input  phase, timing_done, east_pending, west_pending
  );
endinterface

// File: rtl/ddi_phase_scheduler.sv
// Times the light controller's state dwells and picks the next green phase,
// inserting latched east/west priority requests fairly between normal phases.
module ddi_phase_scheduler #(
  parameter int GREEN_CYCLES   = 30,
  parameter int YELLOW_CYCLES  = 5,
  parameter int ALL_RED_CYCLES = 2,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ddi_phase_scheduler_if.master bus
);
  // Light controller state encodings, shared with the controller FSM.
  localparam logic [3:0] S_ALL_RED     = 4'd0;
  localparam logic [3:0] S_P1_GREEN    = 4'd1;
  localparam logic [3:0] S_P1_YELLOW   = 4'd2;
  localparam logic [3:0] S_P2_GREEN    = 4'd3;
  localparam logic [3:0] S_P2_YELLOW   = 4'd4;
  localparam logic [3:0] S_E_GREEN     = 4'd5;
  localparam logic [3:0] S_E_YELLOW    = 4'd6;
  localparam logic [3:0] S_W_GREEN     = 4'd7;
  localparam logic [3:0] S_W_YELLOW    = 4'd8;

  localparam logic [1:0] PH_1 = 2'd0;
  localparam logic [1:0] PH_2 = 2'd1;
  localparam logic [1:0] PH_E = 2'd2;
  localparam logic [1:0] PH_W = 2'd3;

  localparam logic [CNT_W-1:0] GREEN_M1   = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_M1  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALL_RED_M1 = CNT_W'(ALL_RED_CYCLES - 1);

  logic [3:0]       prev_state_q, prev_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic             east_pending_q, east_pending_d;
  logic             west_pending_q, west_pending_d;
  logic             last_normal_q, last_normal_d;
  logic             last_prio_q, last_prio_d;
  logic             last_prio_dir_q, last_prio_dir_d;

  logic             changed;
  logic [CNT_W-1:0] dwell_m1;
  logic [1:0]       next_normal;

  assign changed = (bus.current_state != prev_state_q);

  always_comb begin
    dwell_m1 = ALL_RED_M1;
    case (bus.current_state)
      S_P1_GREEN, S_P2_GREEN, S_E_GREEN, S_W_GREEN:     dwell_m1 = GREEN_M1;
      S_P1_YELLOW, S_P2_YELLOW, S_E_YELLOW, S_W_YELLOW: dwell_m1 = YELLOW_M1;
      default:                                          dwell_m1 = ALL_RED_M1;
    endcase
  end

  assign bus.timing_done  = !rst && !changed && !bus.maintenance && (cnt_q == dwell_m1);
  assign bus.phase        = phase_q;
  assign bus.east_pending = east_pending_q;
  assign bus.west_pending = west_pending_q;

  always_comb begin
    prev_state_d    = bus.current_state;
    cnt_d           = cnt_q;
    east_pending_d  = east_pending_q;
    west_pending_d  = west_pending_q;
    last_normal_d   = last_normal_q;
    last_prio_d     = last_prio_q;
    last_prio_dir_d = last_prio_dir_q;
    phase_d         = phase_q;

    if (bus.maintenance)
      cnt_d = '0;
    else if (changed)
      cnt_d = CNT_W'(1);
    else if (cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);

    // Latches freeze during maintenance; clear-on-service wins over a new set.
    if (!bus.maintenance) begin
      if (bus.east_req && bus.current_state != S_E_GREEN && bus.current_state != S_E_YELLOW)
        east_pending_d = 1'b1;
      if (bus.west_req && bus.current_state != S_W_GREEN && bus.current_state != S_W_YELLOW)
        west_pending_d = 1'b1;
      if (changed && bus.current_state == S_E_GREEN)
        east_pending_d = 1'b0;
      if (changed && bus.current_state == S_W_GREEN)
        west_pending_d = 1'b0;
    end

    if (changed) begin
      case (bus.current_state)
        S_P1_GREEN: begin last_normal_d = 1'b0; last_prio_d = 1'b0; end
        S_P2_GREEN: begin last_normal_d = 1'b1; last_prio_d = 1'b0; end
        S_E_GREEN:  begin last_prio_d = 1'b1; last_prio_dir_d = 1'b0; end
        S_W_GREEN:  begin last_prio_d = 1'b1; last_prio_dir_d = 1'b1; end
        default: ;
      endcase
    end

    // Uses the next-cycle pending values so a request is visible one cycle later.
    next_normal = last_normal_q ? PH_1 : PH_2;
    if (bus.current_state == S_ALL_RED) begin
      if (last_prio_q)
        phase_d = next_normal;
      else if (east_pending_d && west_pending_d)
        phase_d = last_prio_dir_q ? PH_E : PH_W;
      else if (east_pending_d)
        phase_d = PH_E;
      else if (west_pending_d)
        phase_d = PH_W;
      else
        phase_d = next_normal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state_q    <= S_ALL_RED;
      cnt_q           <= '0;
      phase_q         <= PH_1;
      east_pending_q  <= 1'b0;
      west_pending_q  <= 1'b0;
      last_normal_q   <= 1'b1;
      last_prio_q     <= 1'b0;
      last_prio_dir_q <= 1'b1;
    end else begin
      prev_state_q    <= prev_state_d;
      cnt_q           <= cnt_d;
      phase_q         <= phase_d;
      east_pending_q  <= east_pending_d;
      west_pending_q  <= west_pending_d;
      last_normal_q   <= last_normal_d;
      last_prio_q     <= last_prio_d;
      last_prio_dir_q <= last_prio_dir_d;
    end
  end
endmodule

// File: tb/tb_ddi_phase_scheduler.sv
// Closed-loop bench: a behavioural light controller drives the scheduler, and a
// timestamp/history based reference model predicts every output each cycle.
module tb_ddi_phase_scheduler;
  localparam int GREEN = 8;
  localparam int YELLOW = 3;
  localparam int ALLRED = 2;

  localparam logic [3:0] AR = 4'd0, P1G = 4'd1, P1Y = 4'd2, P2G = 4'd3, P2Y = 4'd4;
  localparam logic [3:0] EG = 4'd5, EY = 4'd6, WG = 4'd7, WY = 4'd8, MNT = 4'd9;
  localparam logic [1:0] PH_1 = 2'd0, PH_2 = 2'd1, PH_E = 2'd2, PH_W = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ddi_phase_scheduler_if bus();

  ddi_phase_scheduler #(
    .GREEN_CYCLES(GREEN), .YELLOW_CYCLES(YELLOW), .ALL_RED_CYCLES(ALLRED), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural light controller.
  logic [3:0] ctl_state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctl_state <= AR;
    else if (bus.maintenance) ctl_state <= MNT;
    else if (bus.timing_done) begin
      case (ctl_state)
        AR: case (bus.phase)
              PH_1: ctl_state <= P1G;
              PH_2: ctl_state <= P2G;
              PH_E: ctl_state <= EG;
              default: ctl_state <= WG;
            endcase
        P1G: ctl_state <= P1Y;
        P2G: ctl_state <= P2Y;
        EG:  ctl_state <= EY;
        WG:  ctl_state <= WY;
        default: ctl_state <= AR;
      endcase
    end
  end
  assign bus.current_state = ctl_state;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: state entry time, last maintenance cycle, served-green history.
  int         cyc, m_enter, m_last_maint;
  logic [3:0] m_prev, m_last_green, m_last_normal, m_last_prio;
  logic       m_east, m_west;
  logic [1:0] m_phase;
  logic [3:0] seen[$];

  function automatic int dwell(input logic [3:0] s);
    if (s == P1G || s == P2G || s == EG || s == WG) return GREEN;
    if (s == P1Y || s == P2Y || s == EY || s == WY) return YELLOW;
    return ALLRED;
  endfunction

  function automatic bit is_prio(input logic [3:0] s);
    return (s == EG || s == WG);
  endfunction

  function automatic logic [1:0] normal_next();
    return (m_last_normal == P1G) ? PH_2 : PH_1;
  endfunction

  function automatic logic [1:0] choose(input logic e, input logic w);
    if (is_prio(m_last_green)) return normal_next();
    if (e && w) return (m_last_prio == WG) ? PH_E : PH_W;
    if (e) return PH_E;
    if (w) return PH_W;
    return normal_next();
  endfunction

  task automatic model_reset();
    cyc = 0; m_enter = 0; m_last_maint = -100;
    m_prev = AR; m_last_green = AR; m_last_normal = P2G; m_last_prio = WG;
    m_east = 1'b0; m_west = 1'b0; m_phase = PH_1;
  endtask

  // One clock cycle: check at the falling edge, advance the model after the rising edge.
  task automatic step();
    logic [3:0] s;
    bit         entered, exp_td;
    int         start;
    logic       ne, nw;
    logic [1:0] np;
    @(negedge clk);
    s = bus.current_state;
    entered = (s != m_prev);
    if (entered) m_enter = cyc;
    start = (m_enter > m_last_maint) ? m_enter : m_last_maint + 1;
    exp_td = !bus.maintenance && !entered && (cyc == start + dwell(s) - 1);
    check("timing_done", bus.timing_done, exp_td);
    check("phase", bus.phase, m_phase);
    check("east_pending", bus.east_pending, m_east);
    check("west_pending", bus.west_pending, m_west);
    if (bus.maintenance) m_last_maint = cyc;
    ne = m_east; nw = m_west;
    if (!bus.maintenance) begin
      if (bus.east_req && s != EG && s != EY) ne = 1'b1;
      if (bus.west_req && s != WG && s != WY) nw = 1'b1;
      if (entered && s == EG) ne = 1'b0;
      if (entered && s == WG) nw = 1'b0;
    end
    np = (s == AR) ? choose(ne, nw) : m_phase;
    if (entered && (s == P1G || s == P2G || s == EG || s == WG)) begin
      m_last_green = s;
      if (is_prio(s)) m_last_prio = s; else m_last_normal = s;
      seen.push_back(s);
      $display("green state %0d entered at cycle %0d", s, cyc);
    end
    m_prev = s;
    @(posedge clk);
    #1;
    m_east = ne; m_west = nw; m_phase = np;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_phase", bus.phase, PH_1);
    check("rst_timing_done", bus.timing_done, 1'b0);
    check("rst_east_pending", bus.east_pending, 1'b0);
    check("rst_west_pending", bus.west_pending, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int n = 0;
    while (bus.current_state != s && n < 300) begin step(); n++; end
    check(tag, bus.current_state, s);
  endtask

  task automatic wait_next_green(output logic [3:0] g);
    int n0 = seen.size();
    int n = 0;
    while (seen.size() == n0 && n < 300) begin step(); n++; end
    check("green_timeout", seen.size() > n0, 1'b1);
    g = (seen.size() > n0) ? seen[$] : AR;
  endtask

  logic [3:0] trace[60];
  logic [3:0] g, g2, prev_g, prev_prio;
  int         n_prio, maint_left;
  bit         hold_e, hold_w;

  initial begin
    bus.maintenance = 1'b0; bus.east_req = 1'b0; bus.west_req = 1'b0;
    model_reset();
    #3;
    apply_reset();

    // No requests: fixed state sequence.
    for (int c = 0; c < 60; c++) begin trace[c] = bus.current_state; step(); end
    check("seq_c2_p1g", trace[2], P1G);
    check("seq_c10_p1y", trace[10], P1Y);
    check("seq_c13_allred", trace[13], AR);
    check("seq_c15_p2g", trace[15], P2G);
    check("seq_c23_p2y", trace[23], P2Y);
    check("seq_c26_allred", trace[26], AR);
    check("seq_c28_p1g", trace[28], P1G);

    // Single east pulse during P1G.
    wait_state(P1G, "wait_p1g");
    bus.east_req = 1'b1; step(); bus.east_req = 1'b0;
    check("east_latched", bus.east_pending, 1'b1);
    wait_next_green(g);
    check("east_served", g, EG);
    check("east_cleared", bus.east_pending, 1'b0);
    wait_next_green(g);
    check("after_east_p2g", g, P2G);

    // Both held: priorities alternate, always separated by a normal phase.
    bus.east_req = 1'b1; bus.west_req = 1'b1;
    prev_g = P2G; prev_prio = EG; n_prio = 0;
    for (int i = 0; i < 8; i++) begin
      wait_next_green(g);
      check("no_back_to_back_prio", is_prio(g) && is_prio(prev_g), 1'b0);
      if (is_prio(g)) begin
        check("prio_dir_alternates", g == prev_prio, 1'b0);
        prev_prio = g;
        n_prio++;
      end
      prev_g = g;
    end
    check("prio_count", n_prio, 4);
    bus.east_req = 1'b0; bus.west_req = 1'b0;

    // Maintenance for 5 cycles mid-P2G.
    wait_state(P2G, "wait_p2g");
    repeat (3) step();
    bus.maintenance = 1'b1;
    step(); step();
    check("maint_state", bus.current_state, MNT);
    repeat (3) step();
    bus.maintenance = 1'b0;
    check("maint_fall_no_done", bus.timing_done, 1'b0);
    step();
    check("maint_done_2nd", bus.timing_done, 1'b1);
    step();
    check("maint_to_allred", bus.current_state, AR);

    // Reset in cycle 4 of EASTBOUND_GREEN with west pending.
    wait_state(P1G, "wait_p1g_b");
    bus.east_req = 1'b1; step(); bus.east_req = 1'b0;
    wait_state(EG, "wait_eg");
    bus.west_req = 1'b1; step(); bus.west_req = 1'b0;
    repeat (3) step();
    check("west_pending_before_rst", bus.west_pending, 1'b1);
    #2;
    apply_reset();
    wait_next_green(g);
    check("post_reset_p1g", g, P1G);

    // West request in the timing_done cycle of ALL_RED is deferred one interval.
    wait_state(AR, "wait_allred");
    for (int n = 0; n < 10 && !(bus.current_state == AR && bus.timing_done); n++) step();
    check("allred_done_seen", bus.timing_done, 1'b1);
    bus.west_req = 1'b1; step(); bus.west_req = 1'b0;
    wait_next_green(g);
    check("deferred_normal", g, P2G);
    wait_next_green(g2);
    check("deferred_west", g2, WG);

    // Randomized traffic with occasional maintenance bursts.
    maint_left = 0; hold_e = 0; hold_w = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) hold_e = !hold_e;
      if ($urandom_range(0, 99) == 0) hold_w = !hold_w;
      bus.east_req = hold_e || ($urandom_range(0, 29) == 0);
      bus.west_req = hold_w || ($urandom_range(0, 29) == 0);
      if (maint_left > 0) begin
        bus.maintenance = 1'b1; maint_left--;
      end else begin
        bus.maintenance = 1'b0;
        if ($urandom_range(0, 199) == 0) maint_left = $urandom_range(1, 6);
      end
      step();
    end
    bus.east_req = 1'b0; bus.west_req = 1'b0; bus.maintenance = 1'b0;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
